// File: rtl/pg_ctrl_pkg.sv
// pg_ctrl_pkg: shared state encoding, widths and LFSR step for the PG step sequencer
package pg_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, READ, DECIDE, APPLY, UPDATE} state_t;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int ACT_W = 2;
  localparam int THR_W = 8;
  localparam int CNT_W = 16;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction
endpackage

// File: rtl/lfsr16_galois.sv
// lfsr16_galois: 16-bit Galois right-shift LFSR that advances only when adv is high
module lfsr16_galois
  import pg_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= seed;
    else if (adv) q <= lfsr_next(q);
endmodule

// File: rtl/pg_step_sequencer.sv
// pg_step_sequencer: sequences one epsilon-greedy agent step (Q read, PG decide, apply, Q update)
module pg_step_sequencer
  import pg_ctrl_pkg::*;
#(
  parameter int          PHASE_CYC = 16,
  parameter int          PG_LAT    = 2,
  parameter logic [7:0]  EPS_INIT  = 8'd230,
  parameter logic [7:0]  EPS_STEP  = 8'd1,
  parameter logic [7:0]  EPS_MAX   = 8'd255,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             learning,
  input  logic [CNT_W-1:0] steps,
  output logic             q_rd_en,
  input  logic             q_rd_ack,
  output logic [ACT_W-1:0] arand_a,
  output logic [ACT_W-1:0] arand_b,
  output logic             asel_a,
  output logic             asel_b,
  input  logic [ACT_W-1:0] a_a,
  input  logic [ACT_W-1:0] a_b,
  output logic [ACT_W-1:0] act_a,
  output logic [ACT_W-1:0] act_b,
  output logic             act_valid,
  output logic             upd_en,
  input  logic             upd_done,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_cnt,
  output logic [THR_W-1:0] greedy_thr
);
  localparam logic [15:0]      SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CNT_W-1:0] DEC_LAST = CNT_W'(PG_LAT);
  localparam logic [CNT_W-1:0] APP_LAST = CNT_W'(PHASE_CYC - 1);
  state_t           state;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_nx;
  logic [CNT_W-1:0] cnt;
  logic             stop_lat;
  logic             draw;
  logic             abort;
  logic [8:0]       thr_sum;
  logic [THR_W-1:0] thr_inc;
  always_comb begin
    draw    = (state == READ) && q_rd_ack && !stop;
    abort   = stop && (state == READ || state == DECIDE || state == APPLY);
    lfsr_nx = lfsr_next(lfsr);
    thr_sum = {1'b0, greedy_thr} + {1'b0, EPS_STEP};
    thr_inc = (thr_sum > {1'b0, EPS_MAX}) ? EPS_MAX : thr_sum[7:0];
  end
  lfsr16_galois u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .adv  (draw),
    .seed (SEED_EFF),
    .q    (lfsr)
  );
  // upd_en doubles as the first-UPDATE-cycle marker, so upd_done is ignored while it is high
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      stop_lat   <= 1'b0;
      q_rd_en    <= 1'b0;
      arand_a    <= '0;
      arand_b    <= '0;
      asel_a     <= 1'b0;
      asel_b     <= 1'b0;
      act_a      <= '0;
      act_b      <= '0;
      act_valid  <= 1'b0;
      upd_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_cnt   <= '0;
      greedy_thr <= EPS_INIT;
    end else begin
      done   <= 1'b0;
      upd_en <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        q_rd_en   <= 1'b0;
        act_valid <= 1'b0;
      end else begin
        case (state)
          IDLE:
            if (start && !stop) begin
              state      <= READ;
              busy       <= 1'b1;
              q_rd_en    <= 1'b1;
              step_cnt   <= '0;
              greedy_thr <= EPS_INIT;
              stop_lat   <= 1'b0;
            end
          READ:
            if (draw) begin
              state   <= DECIDE;
              q_rd_en <= 1'b0;
              cnt     <= '0;
              asel_a  <= lfsr_nx[15:8] < greedy_thr;
              asel_b  <= lfsr_nx[7:0] < greedy_thr;
              arand_a <= lfsr_nx[12:11];
              arand_b <= lfsr_nx[4:3];
            end
          DECIDE:
            if (cnt == DEC_LAST) begin
              state     <= APPLY;
              act_a     <= a_a;
              act_b     <= a_b;
              act_valid <= 1'b1;
              cnt       <= '0;
            end else cnt <= cnt + 1'b1;
          APPLY:
            if (cnt == APP_LAST) begin
              state     <= UPDATE;
              act_valid <= 1'b0;
              upd_en    <= 1'b1;
            end else cnt <= cnt + 1'b1;
          UPDATE: begin
            if (stop) stop_lat <= 1'b1;
            if (upd_done && !upd_en) begin
              step_cnt <= step_cnt + 1'b1;
              if (learning) greedy_thr <= thr_inc;
              if (stop || stop_lat) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else if (steps != '0 && step_cnt + 16'd1 == steps) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state   <= READ;
                q_rd_en <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_pg_step_sequencer.sv
// tb_pg_step_sequencer: randomized bench against a step-level reference model of the sequencer
module tb_pg_step_sequencer;
  localparam int PHASE_CYC = 16;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, learning = 1'b0;
  logic [15:0] steps = '0;
  logic        q_rd_ack = 1'b0, upd_done = 1'b0;
  logic [1:0]  a_a = '0, a_b = '0;
  logic        q_rd_en, asel_a, asel_b, act_valid, upd_en, busy, done;
  logic [1:0]  arand_a, arand_b, act_a, act_b;
  logic [15:0] step_cnt;
  logic [7:0]  greedy_thr;
  int checks = 0, failures = 0, ncyc = 0;
  logic [15:0] m_lfsr;
  int          m_thr, m_cnt, m_steps;
  logic        m_lrn, e_sa, e_sb;
  logic [1:0]  e_ra, e_rb;

  pg_step_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .learning(learning), .steps(steps),
    .q_rd_en(q_rd_en), .q_rd_ack(q_rd_ack), .arand_a(arand_a), .arand_b(arand_b),
    .asel_a(asel_a), .asel_b(asel_b), .a_a(a_a), .a_b(a_b), .act_a(act_a), .act_b(act_b),
    .act_valid(act_valid), .upd_en(upd_en), .upd_done(upd_done), .busy(busy), .done(done),
    .step_cnt(step_cnt), .greedy_thr(greedy_thr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    ncyc++;
  endtask

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    m_thr  = 230;
    m_cnt  = 0;
    e_sa = 1'b0; e_sb = 1'b0; e_ra = '0; e_rb = '0;
  endtask

  task automatic model_draw();
    int v;
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    v = int'(m_lfsr);
    e_sa = (v / 256) < m_thr;
    e_sb = (v % 256) < m_thr;
    e_ra = 2'((v / 2048) % 4);
    e_rb = 2'((v / 8) % 4);
  endtask

  task automatic check_draw(input string tag);
    chk({tag, "_asel_a"}, 32'(asel_a), 32'(e_sa));
    chk({tag, "_asel_b"}, 32'(asel_b), 32'(e_sb));
    chk({tag, "_arand_a"}, 32'(arand_a), 32'(e_ra));
    chk({tag, "_arand_b"}, 32'(arand_b), 32'(e_rb));
  endtask

  task automatic start_run(input int s, input bit l);
    steps = 16'(s); learning = l;
    start = 1'b1; cyc(); start = 1'b0;
    m_cnt = 0; m_thr = 230; m_lrn = l; m_steps = s;
    chk("run_busy", 32'(busy), 1);
  endtask

  // stop_at: 0 none, 1 stop in APPLY cycle 5, 2 stop in UPDATE with delayed upd_done
  task automatic do_step(input int ack_dly, input int upd_dly, input int stop_at, output bit ended);
    logic [1:0] av, bv;
    ended = 1'b0;
    chk("rd_en", 32'(q_rd_en), 1);
    chk("cnt_pre", 32'(step_cnt), 32'(m_cnt));
    chk("thr_pre", 32'(greedy_thr), 32'(m_thr));
    for (int i = 0; i < ack_dly; i++) begin
      start = 1'b1; cyc();
      chk("rd_hold", 32'(q_rd_en), 1);
      check_draw("hold");
    end
    start = 1'b0; q_rd_ack = 1'b1; model_draw(); cyc(); q_rd_ack = 1'b0;
    chk("rd_drop", 32'(q_rd_en), 0);
    check_draw("draw");
    av = 2'($urandom_range(0, 3)); bv = 2'($urandom_range(0, 3));
    a_a = av; a_b = bv;
    cyc(); cyc();
    chk("dec_wait", 32'(act_valid), 0);
    cyc();
    chk("apply_start", 32'(act_valid), 1);
    chk("act_a", 32'(act_a), 32'(av));
    chk("act_b", 32'(act_b), 32'(bv));
    a_a = ~av; a_b = ~bv;
    if (stop_at == 1) begin
      repeat (4) cyc();
      stop = 1'b1; cyc(); stop = 1'b0;
      chk("abort_valid", 32'(act_valid), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_cnt", 32'(step_cnt), 32'(m_cnt));
      chk("abort_thr", 32'(greedy_thr), 32'(m_thr));
      ended = 1'b1;
      return;
    end
    repeat (PHASE_CYC - 1) cyc();
    chk("apply_end", 32'(act_valid), 1);
    cyc();
    chk("apply_off", 32'(act_valid), 0);
    chk("upd_en_1", 32'(upd_en), 1);
    cyc();
    chk("upd_en_2", 32'(upd_en), 0);
    if (stop_at == 2) stop = 1'b1;
    for (int i = 0; i < upd_dly; i++) begin
      cyc(); stop = 1'b0;
      chk("upd_wait_busy", 32'(busy), 1);
      chk("upd_wait_cnt", 32'(step_cnt), 32'(m_cnt));
    end
    upd_done = 1'b1; cyc(); upd_done = 1'b0;
    m_cnt = (m_cnt + 1) % 65536;
    if (m_lrn) m_thr = (m_thr + 1 > 255) ? 255 : m_thr + 1;
    ended = (stop_at == 2) || (m_steps != 0 && m_cnt == m_steps);
    chk("done", 32'(done), 32'(ended && stop_at != 2));
    chk("busy_post", 32'(busy), 32'(!ended));
    chk("rd_next", 32'(q_rd_en), 32'(!ended));
    chk("cnt_post", 32'(step_cnt), 32'(m_cnt));
    chk("thr_post", 32'(greedy_thr), 32'(m_thr));
  endtask

  initial begin
    bit ended;
    int t0;
    model_reset();
    cyc(); cyc();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(q_rd_en), 0);
    chk("rst_valid", 32'(act_valid), 0);
    chk("rst_upd_en", 32'(upd_en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", 32'(step_cnt), 0);
    chk("rst_thr", 32'(greedy_thr), 230);
    check_draw("rst");
    rst = 1'b0; cyc();
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", 32'(busy), 0);
    start_run(3, 1'b1);
    t0 = ncyc;
    for (int k = 0; k < 3; k++) do_step(0, 0, 0, ended);
    chk("run_len", 32'(ncyc - t0), 66);
    chk("run_thr", 32'(greedy_thr), 233);
    cyc();
    chk("done_pulse", 32'(done), 0);
    for (int r = 0; r < 6; r++) begin
      start_run($urandom_range(1, 4), 1'($urandom_range(0, 1)));
      do do_step($urandom_range(0, 7), $urandom_range(0, 4), 0, ended); while (!ended);
      cyc();
      chk("rand_done_low", 32'(done), 0);
    end
    start_run(0, 1'b1);
    do_step(2, 1, 0, ended);
    do_step(1, 0, 1, ended);
    cyc();
    chk("abort_idle", 32'(busy), 0);
    start_run(0, 1'b0);
    do_step(0, 0, 0, ended);
    do_step(3, 10, 2, ended);
    cyc();
    chk("stop_upd_done", 32'(done), 0);
    start_run(30, 1'b1);
    do do_step($urandom_range(0, 2), $urandom_range(0, 2), 0, ended); while (!ended);
    chk("sat_thr", 32'(greedy_thr), 255);
    start_run(2, 1'b1);
    q_rd_ack = 1'b1; model_draw(); cyc(); q_rd_ack = 1'b0;
    repeat (6) cyc();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(act_valid), 0);
    chk("mid_rst_thr", 32'(greedy_thr), 230);
    check_draw("mid_rst");
    @(negedge clk); rst = 1'b0;
    cyc();
    start_run(1, 1'b0);
    do_step(0, 0, 0, ended);
    chk("after_rst_end", 32'(ended), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
